// File: rtl/param_fifo.sv
// Synchronous FIFO with first-word-fall-through output and occupancy count.
// Optional sticky ovf/udf flags enabled by defining PARAM_FIFO_ERR_FLAGS_EN.
module param_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  output logic                       ovf,
  output logic                       udf,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // A pop at full frees a slot, so the same-cycle push is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        do_push & ~do_pop: cnt <= cnt + CW'(1);
        do_pop & ~do_push: cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
      if (pop && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Randomized and directed bench for param_fifo against a queue model.
// Error-flag checks follow PARAM_FIFO_ERR_FLAGS_EN.
module tb_param_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic             ovf;
  logic             udf;
  bit               ovf_m;
  bit               udf_m;
`endif

  int checks;
  int failures;
  logic [WIDTH-1:0] q [$];

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    .ovf   (ovf),
    .udf   (udf),
`endif
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue updated from the sampled requests.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      ovf_m = 0;
      udf_m = 0;
`endif
    end else if (clr) begin
      q.delete();
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      ovf_m = 0;
      udf_m = 0;
`endif
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      if (push && was_full && !pop) ovf_m = 1;
      if (pop && was_empty) udf_m = 1;
`endif
      if (pop && !was_empty) void'(q.pop_front());
      if (push && (!was_full || pop)) q.push_back(din);
    end
  end

  // Compare process: outputs reflect registered state, check mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [WIDTH-1:0] exp_d;
      exp_d = (q.size() == 0) ? '0 : q[0];
      chk("model_count", 64'(count), 64'(q.size()));
      chk("model_empty", 64'(empty), 64'(q.size() == 0));
      chk("model_full",  64'(full),  64'(q.size() == DEPTH));
      chk("model_dout",  dout, exp_d);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
      chk("model_ovf", 64'(ovf), 64'(ovf_m));
      chk("model_udf", 64'(udf), 64'(udf_m));
`endif
    end
  end

  task automatic step(input logic c, input logic p,
                      input logic [WIDTH-1:0] d, input logic o);
    @(negedge clk);
    clr  = c;
    push = p;
    din  = d;
    pop  = o;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    #12;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full",  64'(full),  64'd0);
    chk("reset_dout",  dout, 64'd0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_udf", 64'(udf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Fill and drain
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 64'(i), 1'b0);
    idle();
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_full",  64'(full),  64'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("drain_dout", dout, 64'(i));
    end
    idle();
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_dout0", dout, 64'd0);

    // Overflow
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 64'(16 + i), 1'b0);
    step(1'b0, 1'b1, 64'hFF, 1'b0);
    idle();
    chk("ovf_count", 64'(count), 64'd8);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 64'(ovf), 64'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("ovf_drain", dout, 64'(16 + i));
    end

    // Push+pop at full keeps count at DEPTH
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 64'(32 + i), 1'b0);
    step(1'b0, 1'b1, 64'h99, 1'b1);
    idle();
    chk("full_pp_count", 64'(count), 64'd8);
    chk("full_pp_head", dout, 64'd34);
    step(1'b1, 1'b0, '0, 1'b0);

    // Push+pop at empty accepts only the push
    step(1'b0, 1'b1, 64'hAB, 1'b1);
    idle();
    chk("empty_pp_count", 64'(count), 64'd1);
    chk("empty_pp_dout", dout, 64'hAB);

    // Wrap-around with count held at 3
    step(1'b0, 1'b1, 64'hB0, 1'b0);
    step(1'b0, 1'b1, 64'hB1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
    idle();
    chk("wrap_count", 64'(count), 64'd3);

    // clr with push at count 5
    step(1'b0, 1'b1, 64'hC0, 1'b0);
    step(1'b0, 1'b1, 64'hC1, 1'b0);
    step(1'b1, 1'b1, 64'hC2, 1'b0);
    idle();
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_empty", 64'(empty), 64'd1);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("clr_ovf", 64'(ovf), 64'd0);
`endif

    // Underflow
    step(1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("udf_count", 64'(count), 64'd0);
    chk("udf_dout", dout, 64'd0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("udf_flag", 64'(udf), 64'd1);
`endif

    // Asynchronous reset mid-cycle at count 4
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 64'(64 + i), 1'b0);
    idle();
    chk("pre_rst_count", 64'(count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_dout", dout, 64'd0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    chk("async_rst_udf", 64'(udf), 64'd0);
`endif
    #1 rst_n = 1'b1;
    step(1'b0, 1'b1, 64'h55, 1'b0);
    idle();
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_dout", dout, 64'h55);

    // Randomized traffic with shifting push/pop bias
    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 250) % 4;
      automatic logic p = ($urandom_range(0, 9) < 3 + 2 * bias);
      automatic logic o = ($urandom_range(0, 9) < 9 - 2 * bias);
      automatic logic c = ($urandom_range(0, 99) == 0);
      step(c, p, {$urandom, $urandom}, o);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous flush request.
REQ-006 SHALL have port push  input  1  write request for din.
REQ-007 SHALL have port din  input  WIDTH  write data.
REQ-008 SHALL have port pop  input  1  read request; consumes head entry.
REQ-009 SHALL have port dout  output  WIDTH  head entry, first-word-fall-through.
REQ-010 SHALL have port full  output  1  high when count == DEPTH.
REQ-011 SHALL have port empty  output  1  high when count == 0.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have ports ovf and udf  output  1 each  sticky error flags, present only per REQ-031.

Function
REQ-014 SHALL store entries in a DEPTH-entry circular buffer addressed by write and read pointers of $clog2(DEPTH) bits.
REQ-015 SHALL accept push when full is low: write din at the write pointer, then advance the pointer by 1 on that edge.
REQ-016 SHALL accept pop when empty is low: advance the read pointer by 1 on that edge.
REQ-017 SHALL wrap both pointers from DEPTH-1 to 0 with no gap or stall.
REQ-018 SHALL drive dout with the entry at the read pointer when empty is low, and with all zeros when empty is high.
REQ-019 SHALL make a pushed word visible on dout on the cycle after the accepting edge when the FIFO was empty, so push-to-dout latency is 1 cycle.
REQ-020 SHALL ignore push while full is high, including the write, the pointer and count.
REQ-021 SHALL ignore pop while empty is high.
REQ-022 SHALL accept push and pop together when full: pop frees the head, push writes at the tail, and count stays DEPTH.
REQ-023 SHALL, on push and pop together when empty, accept only the push, so count becomes 1 and dout = din on the next cycle.
REQ-024 SHALL, on push and pop together when neither full nor empty, accept both, with count unchanged and FIFO order preserved.
REQ-025 SHALL update count by +1 (push only), -1 (pop only) or 0, and SHALL never let count exceed DEPTH or go below 0.
REQ-026 SHALL give clr priority over push and pop: at the edge, pointers and count go to 0, empty goes high, and same-cycle push/pop are discarded.
REQ-027 SHALL derive full, empty and count from registered state only, with no combinational path from push or pop.

Reset
REQ-028 SHALL, when rst_n is low, immediately set pointers to 0, count = 0, empty = 1, full = 0, dout = 0, ovf = 0 and udf = 0, regardless of clk.
REQ-029 SHALL leave buffer contents unreset, and SHALL never make unwritten contents observable on dout.
REQ-030 SHALL discard all data on reset assertion mid-operation, and SHALL accept push on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL use macro PARAM_FIFO_ERR_FLAGS_EN: when defined, ports ovf and udf exist; ovf sets on push while full without same-cycle pop; udf sets on pop while empty; both stay set until clr or reset.
REQ-032 SHALL, when PARAM_FIFO_ERR_FLAGS_EN is undefined, omit ovf and udf and their logic entirely, with all other behaviour identical.

Verification
REQ-033 SHALL cover fill/drain (WIDTH=64, DEPTH=8): push 0x1..0x8 on consecutive cycles -> full=1, count=8; pop 8 times -> dout sequence 0x1..0x8, then empty=1, dout=0.
REQ-034 SHALL cover overflow: at count=8, push 0xFF alone -> count stays 8, 0xFF never appears on dout, ovf=1 (macro on).
REQ-035 SHALL cover wrap-around: 20 cycles of push+pop from count=3 -> count stays 3, output order equals input order across pointer wrap.
REQ-036 SHALL cover simultaneous ops at boundaries: push+pop at empty -> count=1 with dout=din next cycle; push+pop at full -> count=8.
REQ-037 SHALL cover clr and reset: clr with push at count=5 -> count=0, empty=1, ovf/udf cleared; rst_n low mid-cycle at count=4 -> count=0 without a clock edge.
REQ-038 SHALL cover underflow: pop at empty -> count=0, dout=0, udf=1 (macro on); with the macro off the same stimulus compiles and runs with no ovf/udf ports.
